mult_accumulator: RTL and testbench

Downstream consumer of the multiplier: it captures each `ab` product on the multiplier's `done` pulse and sums `COUNT` consecutive products. It presents each completed sum on a valid/ready output port. Output is the dot-product stage between the multiplier and the result sink. It applies back-pressure only by holding the result, and flags products lost while a result is pending.

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_accumulator.sv | 119 +++++++++++
 tb/tb_mult_accumulator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the multiplier result path.
package mult_pkg;

    typedef enum logic {
        ACC_RUN,
        ACC_HOLD
    } acc_state_t;

    function automatic int acc_width(input int width, input int count);
        return 2 * width + $clog2(count + 1);
    endfunction

endpackage

// File: rtl/mult_accumulator.sv
// Sums COUNT consecutive multiplier products and presents each sum
// on a valid/ready port; products arriving while a sum waits are dropped.
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int COUNT = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  done,
    input  logic [2*WIDTH-1:0]                    ab,
    input  logic                                  clear,
    output logic                                  sum_valid,
    input  logic                                  sum_ready,
    output logic [acc_width(WIDTH, COUNT)-1:0]    sum,
    output logic                                  busy,
    output logic                                  overrun
);

    localparam int ACC_WIDTH = acc_width(WIDTH, COUNT);
    localparam int CNT_W     = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    acc_state_t             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sum_valid_q, sum_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic [ACC_WIDTH-1:0]   ab_ext;

    assign ab_ext = ACC_WIDTH'(ab);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC_RUN;
            acc_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            sum_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            sum_valid_q <= sum_valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        sum_valid_d = sum_valid_q;
        overrun_d   = overrun_q;

        if (clear) begin
            state_d     = ACC_RUN;
            acc_d       = '0;
            sum_d       = '0;
            cnt_d       = '0;
            sum_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            unique case (state_q)
                ACC_RUN: begin
                    if (done) begin
                        if (cnt_q == CNT_LAST) begin
                            sum_d       = acc_q + ab_ext;
                            sum_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            state_d     = ACC_HOLD;
                        end else begin
                            acc_d = acc_q + ab_ext;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ACC_HOLD: begin
                    if (sum_ready) begin
                        sum_valid_d = 1'b0;
                        state_d     = ACC_RUN;
                        if (done) begin
                            // the product accepted on a transfer edge opens the next sum
                            if (COUNT == 1) begin
                                sum_d       = ab_ext;
                                sum_valid_d = 1'b1;
                                state_d     = ACC_HOLD;
                            end else begin
                                acc_d = ab_ext;
                                cnt_d = CNT_W'(1);
                            end
                        end
                    end else if (done) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = ACC_RUN;
            endcase
        end

        // registered so busy never depends combinationally on inputs
        busy_d = (cnt_d != '0) || (state_d == ACC_HOLD);
    end

    assign sum_valid = sum_valid_q;
    assign sum       = sum_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Scoreboard bench for mult_accumulator: a COUNT=4 instance and a
// COUNT=1 streaming instance share clock and reset.
module tb_mult_accumulator;
    import mult_pkg::*;

    localparam int WIDTH = 5;
    localparam int AW4   = acc_width(WIDTH, 4);
    localparam int AW1   = acc_width(WIDTH, 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic               done  = 1'b0;
    logic [2*WIDTH-1:0] ab    = '0;
    logic               clear = 1'b0;
    logic               rdy   = 1'b0;
    logic               valid;
    logic [AW4-1:0]     sum;
    logic               busy;
    logic               ovr;

    logic               done1  = 1'b0;
    logic [2*WIDTH-1:0] ab1    = '0;
    logic               clear1 = 1'b0;
    logic               rdy1   = 1'b0;
    logic               valid1;
    logic [AW1-1:0]     sum1;
    logic               busy1;
    logic               ovr1;

    int checks = 0;
    int errors = 0;
    int unsigned q4[$];
    int unsigned q1[$];

    always #5 clk = ~clk;

    mult_accumulator #(.WIDTH(WIDTH), .COUNT(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .ab        (ab),
        .clear     (clear),
        .sum_valid (valid),
        .sum_ready (rdy),
        .sum       (sum),
        .busy      (busy),
        .overrun   (ovr)
    );

    mult_accumulator #(.WIDTH(WIDTH), .COUNT(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .done      (done1),
        .ab        (ab1),
        .clear     (clear1),
        .sum_valid (valid1),
        .sum_ready (rdy1),
        .sum       (sum1),
        .busy      (busy1),
        .overrun   (ovr1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one clock cycle of stimulus on the COUNT=4 instance; returns #1 after the edge
    task automatic cyc(input logic d, input int a, input logic r, input logic c);
        done  = d;
        ab    = (2*WIDTH)'(a);
        rdy   = r;
        clear = c;
        @(posedge clk);
        #1;
        done  = 1'b0;
        clear = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && valid && rdy && !clear) begin
            chk("sb4_has_entry", 32'(q4.size() > 0), 1);
            if (q4.size() > 0) chk("sum4", 32'(sum), q4.pop_front());
        end
        if (!rst && valid1 && rdy1 && !clear1) begin
            chk("sb1_has_entry", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) chk("sum1", 32'(sum1), q1.pop_front());
        end
    end

    initial begin
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovr", 32'(ovr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 1, 0);

        // basic sum of four 31*31 products
        cyc(1, 961, 1, 0);
        chk("basic_busy1", 32'(busy), 1);
        chk("basic_nvalid", 32'(valid), 0);
        cyc(1, 961, 1, 0);
        cyc(1, 961, 1, 0);
        q4.push_back(3844);
        cyc(1, 961, 1, 0);
        chk("basic_valid", 32'(valid), 1);
        chk("basic_sum", 32'(sum), 3844);
        chk("basic_busy4", 32'(busy), 1);
        cyc(0, 0, 1, 0);
        chk("basic_xfer_valid", 32'(valid), 0);
        chk("basic_xfer_busy", 32'(busy), 0);

        // back-pressure and overrun
        cyc(1, 1, 0, 0);
        cyc(1, 2, 0, 0);
        cyc(1, 3, 0, 0);
        q4.push_back(10);
        cyc(1, 4, 0, 0);
        chk("bp_valid", 32'(valid), 1);
        chk("bp_sum", 32'(sum), 10);
        chk("bp_ovr0", 32'(ovr), 0);
        cyc(1, 7, 0, 0);
        chk("bp_ovr1", 32'(ovr), 1);
        chk("bp_sum_held", 32'(sum), 10);
        chk("bp_valid_held", 32'(valid), 1);
        cyc(0, 0, 1, 0);
        chk("bp_xfer_valid", 32'(valid), 0);
        chk("bp_ovr_sticky", 32'(ovr), 1);
        cyc(0, 0, 0, 1);
        chk("bp_clear_ovr", 32'(ovr), 0);

        // transfer and first product of next sum on the same edge
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        q4.push_back(4);
        cyc(1, 1, 0, 0);
        chk("sim_hold", 32'(valid), 1);
        cyc(1, 5, 1, 0);
        chk("sim_xfer_valid", 32'(valid), 0);
        chk("sim_busy", 32'(busy), 1);
        cyc(1, 5, 1, 0);
        cyc(1, 5, 1, 0);
        q4.push_back(20);
        cyc(1, 5, 1, 0);
        chk("sim_valid", 32'(valid), 1);
        chk("sim_sum", 32'(sum), 20);
        cyc(0, 0, 1, 0);

        // clear mid-accumulation, simultaneous done ignored
        cyc(1, 100, 1, 0);
        cyc(1, 200, 1, 0);
        cyc(1, 50, 1, 1);
        chk("clr_busy", 32'(busy), 0);
        chk("clr_ovr", 32'(ovr), 0);
        chk("clr_valid", 32'(valid), 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 0);
        q4.push_back(4);
        cyc(1, 1, 1, 0);
        chk("clr_sum", 32'(sum), 4);
        cyc(0, 0, 1, 0);

        // async reset while holding a result with overrun set
        cyc(1, 2, 0, 0);
        cyc(1, 2, 0, 0);
        cyc(1, 2, 0, 0);
        cyc(1, 2, 0, 0);
        cyc(1, 2, 0, 0);
        chk("ar_pre_valid", 32'(valid), 1);
        chk("ar_pre_ovr", 32'(ovr), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(valid), 0);
        chk("ar_sum", 32'(sum), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_ovr", 32'(ovr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0);

        // COUNT=1 streaming
        rdy1  = 1'b1;
        done1 = 1'b1;
        ab1   = 3;
        q1.push_back(3);
        @(posedge clk);
        #1;
        chk("s1_valid_a", 32'(valid1), 1);
        ab1 = 6;
        q1.push_back(6);
        @(posedge clk);
        #1;
        chk("s1_valid_b", 32'(valid1), 1);
        ab1 = 9;
        q1.push_back(9);
        @(posedge clk);
        #1;
        chk("s1_valid_c", 32'(valid1), 1);
        chk("s1_sum_c", 32'(sum1), 9);
        done1 = 1'b0;
        @(posedge clk);
        #1;
        chk("s1_drained_valid", 32'(valid1), 0);
        chk("s1_ovr", 32'(ovr1), 0);

        cyc(0, 0, 0, 0);
        chk("sb4_drain", q4.size(), 0);
        chk("sb1_drain", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
